// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and handles load-use bubbles and branch/jump flushes.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_take_branch,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_MemtoReg,
    output logic                  ex_Branch,
    output logic                  ex_ALUorig,
    output logic                  ex_Jump,
    output logic                  ex_Jump2,
    output logic [1:0]            ex_ALUOp,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_RegWrite,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  mem_MemtoReg,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam bit             MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
    localparam logic [1:0]     STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  alu_orig;
        logic                  memto_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  jump2;
        logic [1:0]            alu_op;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  memto_reg;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  memto_reg;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    idex_t dec_s;
    logic  rs1_used_s;
    logic  rs2_used_s;
    logic  hz_s;
    logic  fl_s;
    logic  load_bubble_s;
    logic  count_bubble_s;

    // Opcode decode into the control bundle; rd is kept only for register-writing ops.
    always_comb begin
        dec_s      = '0;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OP_RTYPE: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_op    = 2'b10;
                    dec_s.rd        = id_rd;
                    rs1_used_s      = 1'b1;
                    rs2_used_s      = 1'b1;
                end
                OP_OPIMM: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_orig  = 1'b1;
                    dec_s.rd        = id_rd;
                    rs1_used_s      = 1'b1;
                end
                OP_LOAD: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_orig  = 1'b1;
                    dec_s.memto_reg = 1'b1;
                    dec_s.mem_read  = 1'b1;
                    dec_s.rd        = id_rd;
                    rs1_used_s      = 1'b1;
                end
                OP_STORE: begin
                    dec_s.alu_orig  = 1'b1;
                    dec_s.mem_write = 1'b1;
                    rs1_used_s      = 1'b1;
                    rs2_used_s      = 1'b1;
                end
                OP_BRANCH: begin
                    dec_s.branch    = 1'b1;
                    dec_s.alu_op    = 2'b01;
                    rs1_used_s      = 1'b1;
                    rs2_used_s      = 1'b1;
                end
                OP_JAL: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.jump      = 1'b1;
                    dec_s.rd        = id_rd;
                end
                OP_JALR: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.alu_orig  = 1'b1;
                    dec_s.jump      = 1'b1;
                    dec_s.jump2     = 1'b1;
                    dec_s.rd        = id_rd;
                    rs1_used_s      = 1'b1;
                end
                default: begin
                    dec_s = '0;
                end
            endcase
        end else begin
            dec_s = '0;
        end
    end

    assign hz_s = idex_q.mem_read && (idex_q.rd != '0) && id_valid &&
                  ((rs1_used_s && (id_rs1 == idex_q.rd)) ||
                   (rs2_used_s && (id_rs2 == idex_q.rd)));
    assign fl_s = ex_take_branch || idex_q.jump;

    // Hazard FSM: flush beats stall; STALL counts down the remaining bubbles.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        load_bubble_s  = 1'b0;
        count_bubble_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fl_s) begin
                    ifid_flush    = 1'b1;
                    load_bubble_s = 1'b1;
                end else if (hz_s) begin
                    pc_stall       = 1'b1;
                    ifid_stall     = 1'b1;
                    load_bubble_s  = 1'b1;
                    count_bubble_s = 1'b1;
                    if (MULTI_STALL) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    load_bubble_s = 1'b0;
                end
            end
            ST_STALL: begin
                load_bubble_s = 1'b1;
                if (fl_s) begin
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                    cnt_d      = 2'd0;
                end else begin
                    pc_stall       = 1'b1;
                    ifid_stall     = 1'b1;
                    count_bubble_s = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Next-state values for the stage registers and the saturating bubble counter.
    always_comb begin
        if (load_bubble_s) begin
            idex_d = '0;
        end else begin
            idex_d = dec_s;
        end
        exmem_d = '{reg_write: idex_q.reg_write, mem_read: idex_q.mem_read,
                    mem_write: idex_q.mem_write, memto_reg: idex_q.memto_reg,
                    rd: idex_q.rd};
        memwb_d = '{reg_write: exmem_q.reg_write, memto_reg: exmem_q.memto_reg,
                    rd: exmem_q.rd};
        if (count_bubble_s && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_RegWrite  = idex_q.reg_write;
    assign ex_MemRead   = idex_q.mem_read;
    assign ex_MemWrite  = idex_q.mem_write;
    assign ex_MemtoReg  = idex_q.memto_reg;
    assign ex_Branch    = idex_q.branch;
    assign ex_ALUorig   = idex_q.alu_orig;
    assign ex_Jump      = idex_q.jump;
    assign ex_Jump2     = idex_q.jump2;
    assign ex_ALUOp     = idex_q.alu_op;
    assign ex_rd        = idex_q.rd;
    assign mem_RegWrite = exmem_q.reg_write;
    assign mem_MemRead  = exmem_q.mem_read;
    assign mem_MemWrite = exmem_q.mem_write;
    assign mem_MemtoReg = exmem_q.memto_reg;
    assign mem_rd       = exmem_q.rd;
    assign wb_RegWrite  = memwb_q.reg_write;
    assign wb_MemtoReg  = memwb_q.memto_reg;
    assign wb_rd        = memwb_q.rd;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with single-bubble load-use,
// one with three bubbles, both fed from the same ID-stage stimulus.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_take_branch;

    logic       pcs_a, ifs_a, iff_a, pcs_b, ifs_b, iff_b;
    logic       exrw_a, exmr_a, exmw_a, exm2r_a, exbr_a, exao_a, exj_a, exj2_a;
    logic       exrw_b, exmr_b, exmw_b, exm2r_b, exbr_b, exao_b, exj_b, exj2_b;
    logic [1:0] exop_a, exop_b;
    logic [4:0] exrd_a, exrd_b, memrd_a, memrd_b, wbrd_a, wbrd_b;
    logic       memrw_a, memmr_a, memmw_a, memm2r_a, wbrw_a, wbm2r_a;
    logic       memrw_b, memmr_b, memmw_b, memm2r_b, wbrw_b, wbm2r_b;
    logic [15:0] cnt_a, cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_take_branch(ex_take_branch),
        .pc_stall(pcs_a), .ifid_stall(ifs_a), .ifid_flush(iff_a),
        .ex_RegWrite(exrw_a), .ex_MemRead(exmr_a), .ex_MemWrite(exmw_a),
        .ex_MemtoReg(exm2r_a), .ex_Branch(exbr_a), .ex_ALUorig(exao_a),
        .ex_Jump(exj_a), .ex_Jump2(exj2_a), .ex_ALUOp(exop_a), .ex_rd(exrd_a),
        .mem_RegWrite(memrw_a), .mem_MemRead(memmr_a), .mem_MemWrite(memmw_a),
        .mem_MemtoReg(memm2r_a), .mem_rd(memrd_a),
        .wb_RegWrite(wbrw_a), .wb_MemtoReg(wbm2r_a), .wb_rd(wbrd_a),
        .stall_count(cnt_a)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_take_branch(ex_take_branch),
        .pc_stall(pcs_b), .ifid_stall(ifs_b), .ifid_flush(iff_b),
        .ex_RegWrite(exrw_b), .ex_MemRead(exmr_b), .ex_MemWrite(exmw_b),
        .ex_MemtoReg(exm2r_b), .ex_Branch(exbr_b), .ex_ALUorig(exao_b),
        .ex_Jump(exj_b), .ex_Jump2(exj2_b), .ex_ALUOp(exop_b), .ex_rd(exrd_b),
        .mem_RegWrite(memrw_b), .mem_MemRead(memmr_b), .mem_MemWrite(memmw_b),
        .mem_MemtoReg(memm2r_b), .mem_rd(memrd_b),
        .wb_RegWrite(wbrw_b), .wb_MemtoReg(wbm2r_b), .wb_rd(wbrd_b),
        .stall_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ex_take_branch = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({exrw_a, exmr_a, exmw_a, exm2r_a, exbr_a, exao_a, exj_a, exj2_a, exop_a, exrd_a} !== 15'd0) begin
            failures++;
            $display("FAIL reset_ex_a: got %0h expected 0", {exrw_a, exmr_a, exmw_a, exm2r_a, exbr_a, exao_a, exj_a, exj2_a, exop_a, exrd_a});
        end
        checks++;
        if ({memrw_a, memmr_a, memmw_a, memm2r_a, memrd_a, wbrw_a, wbm2r_a, wbrd_a} !== 16'd0) begin
            failures++;
            $display("FAIL reset_memwb_a: got %0h expected 0", {memrw_a, memmr_a, memmw_a, memm2r_a, memrd_a, wbrw_a, wbm2r_a, wbrd_a});
        end
        checks++;
        if ({pcs_a, ifs_a, iff_a, pcs_b, ifs_b, iff_b} !== 6'd0) begin
            failures++;
            $display("FAIL reset_hazard: got %0h expected 0", {pcs_a, ifs_a, iff_a, pcs_b, ifs_b, iff_b});
        end
        checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_rtype_propagation();
        do_reset();
        drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd5);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (exrw_a !== 1'b1 || exop_a !== 2'b10 || exrd_a !== 5'd5 || exao_a !== 1'b0) begin
            failures++;
            $display("FAIL rtype_ex: got rw=%0b op=%0b rd=%0d ao=%0b expected rw=1 op=10 rd=5 ao=0", exrw_a, exop_a, exrd_a, exao_a);
        end
        tick();
        checks++;
        if (memrd_a !== 5'd5 || memrw_a !== 1'b1 || exrw_a !== 1'b0) begin
            failures++;
            $display("FAIL rtype_mem: got rd=%0d rw=%0b exrw=%0b expected rd=5 rw=1 exrw=0", memrd_a, memrw_a, exrw_a);
        end
        tick();
        checks++;
        if (wbrw_a !== 1'b1 || wbrd_a !== 5'd5 || wbm2r_a !== 1'b0) begin
            failures++;
            $display("FAIL rtype_wb: got rw=%0b rd=%0d m2r=%0b expected rw=1 rd=5 m2r=0", wbrw_a, wbrd_a, wbm2r_a);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, OP_RTYPE, 5'd1, 5'd3, 5'd7);
        checks++;
        if (pcs_a !== 1'b1 || ifs_a !== 1'b1 || pcs_b !== 1'b1 || iff_a !== 1'b0) begin
            failures++;
            $display("FAIL lu_detect: got pcs_a=%0b ifs_a=%0b pcs_b=%0b iff_a=%0b expected 1 1 1 0", pcs_a, ifs_a, pcs_b, iff_a);
        end
        tick();
        checks++;
        if (exrw_a !== 1'b0 || cnt_a !== 16'd1 || pcs_a !== 1'b0) begin
            failures++;
            $display("FAIL lu_n1_bubble: got exrw=%0b cnt=%0d pcs=%0b expected 0 1 0", exrw_a, cnt_a, pcs_a);
        end
        checks++;
        if (exrw_b !== 1'b0 || cnt_b !== 16'd1 || pcs_b !== 1'b1) begin
            failures++;
            $display("FAIL lu_n3_stall1: got exrw=%0b cnt=%0d pcs=%0b expected 0 1 1", exrw_b, cnt_b, pcs_b);
        end
        tick();
        checks++;
        if (exrw_a !== 1'b1 || exrd_a !== 5'd7) begin
            failures++;
            $display("FAIL lu_n1_dep: got exrw=%0b rd=%0d expected 1 7", exrw_a, exrd_a);
        end
        checks++;
        if (exrw_b !== 1'b0 || cnt_b !== 16'd2 || pcs_b !== 1'b1) begin
            failures++;
            $display("FAIL lu_n3_stall2: got exrw=%0b cnt=%0d pcs=%0b expected 0 2 1", exrw_b, cnt_b, pcs_b);
        end
        tick();
        checks++;
        if (exrw_b !== 1'b0 || cnt_b !== 16'd3 || pcs_b !== 1'b0) begin
            failures++;
            $display("FAIL lu_n3_stall3: got exrw=%0b cnt=%0d pcs=%0b expected 0 3 0", exrw_b, cnt_b, pcs_b);
        end
        tick();
        checks++;
        if (exrw_b !== 1'b1 || exrd_b !== 5'd7 || cnt_b !== 16'd3 || cnt_a !== 16'd1) begin
            failures++;
            $display("FAIL lu_n3_dep: got exrw=%0b rd=%0d cnt_b=%0d cnt_a=%0d expected 1 7 3 1", exrw_b, exrd_b, cnt_b, cnt_a);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_RTYPE, 5'd0, 5'd0, 5'd6);
        checks++;
        if (pcs_a !== 1'b0 || pcs_b !== 1'b0) begin
            failures++;
            $display("FAIL nh_x0: got pcs_a=%0b pcs_b=%0b expected 0 0", pcs_a, pcs_b);
        end
        tick();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd4);
        checks++;
        if (exrw_a !== 1'b1 || exrd_a !== 5'd6) begin
            failures++;
            $display("FAIL nh_x0_pass: got exrw=%0b rd=%0d expected 1 6", exrw_a, exrd_a);
        end
        tick();
        drive(1'b1, OP_OPIMM, 5'd1, 5'd4, 5'd8);
        checks++;
        if (pcs_a !== 1'b0 || pcs_b !== 1'b0 || exmr_a !== 1'b1) begin
            failures++;
            $display("FAIL nh_unused_rs2: got pcs_a=%0b pcs_b=%0b exmr=%0b expected 0 0 1", pcs_a, pcs_b, exmr_a);
        end
        drive(1'b1, OP_OPIMM, 5'd4, 5'd0, 5'd8);
        checks++;
        if (pcs_a !== 1'b1) begin
            failures++;
            $display("FAIL hz_opimm_rs1: got pcs=%0b expected 1", pcs_a);
        end
        drive(1'b1, OP_OPIMM, 5'd1, 5'd4, 5'd8);
        tick();
        checks++;
        if (exao_a !== 1'b1 || exrd_a !== 5'd8 || exop_a !== 2'b00 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL nh_opimm_ex: got ao=%0b rd=%0d op=%0b cnt=%0d expected 1 8 0 0", exao_a, exrd_a, exop_a, cnt_a);
        end
    endtask

    task automatic test_flush_in_stall();
        do_reset();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, OP_RTYPE, 5'd2, 5'd3, 5'd7);
        tick();
        ex_take_branch = 1'b1;
        #1;
        checks++;
        if (iff_b !== 1'b1 || pcs_b !== 1'b0 || ifs_b !== 1'b0) begin
            failures++;
            $display("FAIL fl_stall: got iff=%0b pcs=%0b ifs=%0b expected 1 0 0", iff_b, pcs_b, ifs_b);
        end
        tick();
        ex_take_branch = 1'b0;
        #1;
        checks++;
        if (exrw_b !== 1'b0 || cnt_b !== 16'd1 || pcs_b !== 1'b0 || iff_b !== 1'b0) begin
            failures++;
            $display("FAIL fl_to_run: got exrw=%0b cnt=%0d pcs=%0b iff=%0b expected 0 1 0 0", exrw_b, cnt_b, pcs_b, iff_b);
        end
        tick();
        checks++;
        if (exrw_b !== 1'b1 || exrd_b !== 5'd7) begin
            failures++;
            $display("FAIL fl_resume: got exrw=%0b rd=%0d expected 1 7", exrw_b, exrd_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, OP_RTYPE, 5'd3, 5'd2, 5'd9);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (pcs_b !== 1'b0 || cnt_b !== 16'd0 || exrw_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stall: got pcs=%0b cnt=%0d exrw=%0b expected 0 0 0", pcs_b, cnt_b, exrw_b);
        end
        tick();
        checks++;
        if (exrw_b !== 1'b1 || exrd_b !== 5'd9) begin
            failures++;
            $display("FAIL rst_mid_stall_run: got exrw=%0b rd=%0d expected 1 9", exrw_b, exrd_b);
        end
    endtask

    task automatic test_jalr_unknown();
        do_reset();
        drive(1'b1, OP_JALR, 5'd1, 5'd0, 5'd1);
        tick();
        drive(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd9);
        checks++;
        if (exj_a !== 1'b1 || exj2_a !== 1'b1 || exao_a !== 1'b1 || exrw_a !== 1'b1 || exop_a !== 2'b00) begin
            failures++;
            $display("FAIL jalr_ex: got j=%0b j2=%0b ao=%0b rw=%0b op=%0b expected 1 1 1 1 00", exj_a, exj2_a, exao_a, exrw_a, exop_a);
        end
        checks++;
        if (iff_a !== 1'b1 || pcs_a !== 1'b0) begin
            failures++;
            $display("FAIL jalr_flush: got iff=%0b pcs=%0b expected 1 0", iff_a, pcs_a);
        end
        tick();
        drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd9);
        checks++;
        if (exrw_a !== 1'b0 || exj_a !== 1'b0 || cnt_a !== 16'd0 || iff_a !== 1'b0) begin
            failures++;
            $display("FAIL jalr_bubble: got rw=%0b j=%0b cnt=%0d iff=%0b expected 0 0 0 0", exrw_a, exj_a, cnt_a, iff_a);
        end
        tick();
        drive(1'b0, OP_RTYPE, 5'd1, 5'd2, 5'd9);
        checks++;
        if ({exrw_a, exmr_a, exmw_a, exm2r_a, exbr_a, exao_a, exj_a, exj2_a, exop_a, exrd_a} !== 15'd0) begin
            failures++;
            $display("FAIL bad_opcode: got %0h expected 0", {exrw_a, exmr_a, exmw_a, exm2r_a, exbr_a, exao_a, exj_a, exj2_a, exop_a, exrd_a});
        end
        tick();
        checks++;
        if ({exrw_a, exop_a, exrd_a} !== 8'd0) begin
            failures++;
            $display("FAIL invalid_id: got %0h expected 0", {exrw_a, exop_a, exrd_a});
        end
    endtask

    initial begin
        test_reset();
        test_rtype_propagation();
        test_load_use();
        test_no_hazard();
        test_flush_in_stall();
        test_reset_mid_stall();
        test_jalr_unknown();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined successor to the combinational main decoder. It decodes the ID-stage opcode into the standard control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and inserts a parametrised number of bubbles, and it flushes on taken branches and jumps. A saturating stall counter supports performance measurement. It sits between the IF/ID register and the datapath stage registers of the 5-stage RISC-V core.

## Interface
- REG_ADDR_W, 5, register-index width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard. Legal range 1..3.
- CNT_W, 16, width of the stall performance counter.

- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  7  instruction[6:0].
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register fields of the ID instruction.
- ex_take_branch  in  1  EX-stage branch condition true (ALU zero qualified by ex_Branch).
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to a bubble.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUorig, ex_Jump, ex_Jump2  out  1 each  ID/EX control.
- ex_ALUOp  out  2  ID/EX ALU op class.
- ex_rd  out  REG_ADDR_W  ID/EX destination register.
- mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg  out  1 each  EX/MEM control.
- mem_rd  out  REG_ADDR_W  EX/MEM destination register.
- wb_RegWrite, wb_MemtoReg  out  1 each  MEM/WB control.
- wb_rd  out  REG_ADDR_W  MEM/WB destination register.
- stall_count  out  CNT_W  saturating count of bubble cycles inserted.

## Operation
- **Decode** (combinational, ID; fields listed are RegWrite / ALUorig / MemtoReg / MemRead / MemWrite / Branch / Jump / Jump2 / ALUOp):
  - RTYPE: 1/0/0/0/0/0/0/0/10
  - OPIMM: 1/1/0/0/0/0/0/0/00
  - LOAD: 1/1/1/1/0/0/0/0/00
  - STORE: 0/1/0/0/1/0/0/0/00
  - BRANCH: 0/0/0/0/0/1/0/0/01
  - JAL: 1/0/0/0/0/0/1/0/00
  - JALR: 1/1/0/0/0/0/1/1/00
  - Any other opcode, or id_valid=0: all zero.
  - Every field is defined for every opcode; no latches.
- **Source use**:
  - rs1 is used by RTYPE, OPIMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by RTYPE, STORE, BRANCH.
- **Load-use hazard** (hz) = ex_MemRead & ex_rd≠0 & id_valid & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
- **Flush** (fl) = ex_take_branch | ex_Jump.
- **FSM** states: RUN, STALL; counter cnt is 2 bits.
  - RUN, fl: ifid_flush=1; ID/EX loads a bubble; stay in RUN.
  - RUN, hz & !fl: pc_stall=ifid_stall=1; ID/EX loads a bubble. If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - RUN, neither: ID/EX loads the decoded bundle.
  - STALL: pc_stall=ifid_stall=1; ID/EX loads a bubble. If cnt==1, go to RUN; otherwise cnt decrements.
  - STALL, fl (possible only from an older instruction in EX): flush wins. ifid_flush=1, stalls deasserted, go to RUN.
- **Priority**: reset > flush > stall.
- **Bubble**: all control bits 0, rd=0.
- **Stage advance**: EX/MEM and MEM/WB always advance; they are never stalled.
- **stall_count**: increments on every cycle that inserts a load-use bubble (RUN-hz or STALL). It saturates at all-ones. Flush bubbles are not counted.

## Timing
- **Reset** (synchronous): every stage register clears to bubble, FSM goes to RUN, cnt=0, stall_count=0.
- **Hazard outputs**: pc_stall, ifid_stall and ifid_flush are combinational from the ID inputs and the ID/EX registers, valid in the same cycle.
- **Stage latency**: a bundle decoded in cycle t appears on ex_* at t+1, mem_* at t+2, wb_* at t+3.
- **Load-use cost**: exactly LOAD_STALL_CYCLES bubbles in ex_*. The dependent instruction reaches ex_* at t+1+LOAD_STALL_CYCLES.
- **No re-detection**: after the first bubble the load has left EX, so the same load never re-triggers.
- **Reset mid-STALL**: returns to RUN next cycle with no further bubbles.

## Test plan
- **Reset**: assert reset 2 cycles → all ex_/mem_/wb_ outputs 0, pc_stall=0, stall_count=0.
- **R-type propagation**: RTYPE with rd=5 → ex_RegWrite=1 and ex_ALUOp=10 at t+1; mem_rd=5 at t+2; wb_RegWrite=1 at t+3.
- **Load-use, N=1**: LOAD rd=3, then RTYPE rs2=3 → one cycle pc_stall=1, one bubble, stall_count=1. With N=3, three bubbles and stall_count=3.
- **No hazard on x0 or unused source**: LOAD rd=0 followed by a user of x0 → no stall. LOAD rd=4 followed by OPIMM whose rs2 field is 4 → no stall.
- **Flush during STALL**: N=3, a taken branch sits ahead of the load-use pair, with ex_take_branch=1 in the second stall cycle → ifid_flush=1, pc_stall=0, FSM returns to RUN.
- **JALR / unknown opcode**: JALR → ex_Jump=ex_Jump2=ex_ALUorig=1, and the next cycle flushes. Opcode 0x7F → all-zero bundle.
